// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: issue/writeback control around a fixed-latency signed multiplier array, owning HI/LO.
// Optional feature macro MULT_UNSIGNED_EN: MULTU via the signed array plus a HI correction adder.
module mult_hilo_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        mul_start,
    output logic [31:0] mul_in1,
    output logic [31:0] mul_in2,
    input  logic [63:0] mul_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]       OP_MTHI  = 2'b10;
    localparam logic [1:0]       OP_MTLO  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             acc_mul;
    logic             acc_mthi;
    logic             acc_mtlo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

`ifdef MULT_UNSIGNED_EN
    logic op_unsigned;

    // Reinterpreting a signed product as unsigned only disturbs the upper word:
    // each negative operand contributes 2**32 times the other operand.
    function automatic logic [31:0] unsigned_hi_fix(input logic [31:0] p_hi,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
        logic [31:0] add_a;
        logic [31:0] add_b;
        add_a = a[31] ? b : 32'h0;
        add_b = b[31] ? a : 32'h0;
        return p_hi + add_a + add_b;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (acc_mul) state_nxt = ST_RUN;
            ST_RUN:     if (cnt == CNT_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Ready depends on state alone so the requester never sees a comb loop through req_valid.
    always_comb begin
        req_ready = (state == ST_IDLE);
        acc_mul   = req_ready & req_valid & ~req_op[1];
        acc_mthi  = req_ready & req_valid & (req_op == OP_MTHI);
        acc_mtlo  = req_ready & req_valid & (req_op == OP_MTLO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (state_nxt == ST_RUN);
            mul_start <= (state_nxt == ST_RUN);
            done      <= (state == ST_CAPTURE);
            if (acc_mul) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Operands move only on acceptance so the array sees them stable for the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_in1 <= 32'h0;
            mul_in2 <= 32'h0;
        end else if (acc_mul) begin
            mul_in1 <= req_a;
            mul_in2 <= req_b;
        end
    end

`ifdef MULT_UNSIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_unsigned <= 1'b0;
        end else if (acc_mul) begin
            op_unsigned <= req_op[0];
        end
    end

    always_comb begin
        res_lo = mul_out[31:0];
        res_hi = op_unsigned ? unsigned_hi_fix(mul_out[63:32], mul_in1, mul_in2)
                             : mul_out[63:32];
    end
`else
    always_comb begin
        res_lo = mul_out[31:0];
        res_hi = mul_out[63:32];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (state == ST_CAPTURE) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (acc_mthi) hi <= req_a;
            if (acc_mtlo) lo <= req_a;
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: behavioural array model plus a HI/LO reference model, random and directed cases.
module tb_mult_hilo_ctrl;

    localparam int LAT = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op    = 2'b00;
    logic [31:0] req_a     = 32'h0;
    logic [31:0] req_b     = 32'h0;
    logic        req_ready;
    logic        mul_start;
    logic [31:0] mul_in1;
    logic [31:0] mul_in2;
    logic [63:0] mul_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    logic [63:0] arr [LAT];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    int          n_chk = 0;
    int          n_bad = 0;

    mult_hilo_ctrl #(.MUL_LAT(LAT), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_start (mul_start),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
    endfunction

    // Signed multiplier array: LAT register stages from operands to mul_out.
    always @(posedge clk) begin
        arr[0] <= smul(mul_in1, mul_in2);
        for (int i = 1; i < LAT; i++) arr[i] <= arr[i-1];
    end
    assign mul_out = arr[LAT-1];

    function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
`ifdef MULT_UNSIGNED_EN
        if (op == 2'b01) return {32'h0, a} * {32'h0, b};
`endif
        if (op == 2'b11) return 64'h0;
        return smul(a, b);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Multiply transaction; optionally holds an MTHI request throughout so it must wait for IDLE.
    task automatic do_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input logic [31:0] hv);
        logic [63:0] p;
        p = ref_prod(op, a, b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        check_eq("ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_op = 2'b10;
            req_a  = hv;
            req_b  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= LAT + 2; k++) begin
            check_eq("busy", busy, k <= LAT);
            check_eq("start", mul_start, k <= LAT);
            check_eq("done", done, k == LAT + 2);
            check_eq("ready", req_ready, k == LAT + 2);
            if (k <= LAT) begin
                check_eq("in1", mul_in1, a);
                check_eq("in2", mul_in2, b);
            end
            if (k == LAT + 2) begin
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            check_eq("hi", hi, m_hi);
            check_eq("lo", lo, m_lo);
            if (k < LAT + 2) @(negedge clk);
        end
        if (hold) begin
            @(negedge clk);
            req_valid = 1'b0;
            m_hi = hv;
            check_eq("hold_hi", hi, m_hi);
            check_eq("hold_lo", lo, m_lo);
            check_eq("hold_done", done, 0);
            check_eq("hold_busy", busy, 0);
        end
    endtask

    task automatic do_mov(input logic is_lo, input logic [31:0] v);
        req_valid = 1'b1;
        req_op    = is_lo ? 2'b11 : 2'b10;
        req_a     = v;
        req_b     = $urandom;
        check_eq("ready_mv", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (is_lo) m_lo = v;
        else       m_hi = v;
        check_eq("mv_hi", hi, m_hi);
        check_eq("mv_lo", lo, m_lo);
        check_eq("mv_busy", busy, 0);
        check_eq("mv_done", done, 0);
        check_eq("mv_start", mul_start, 0);
    endtask

    task automatic do_abort(input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        check_eq("abort_hi", hi, m_hi);
        check_eq("abort_lo", lo, m_lo);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_start", mul_start, 0);
        check_eq("abort_in1", mul_in1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_done", done, 0);
            check_eq("abort_idle_busy", busy, 0);
            check_eq("abort_keep_hi", hi, m_hi);
            check_eq("abort_keep_lo", lo, m_lo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] op;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_start", mul_start, 0);
        check_eq("rst_in1", mul_in1, 0);
        check_eq("rst_in2", mul_in2, 0);
        check_eq("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_mul(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'h0);
        check_eq("t1_hi", hi, 32'hFFFF_FFFF);
        check_eq("t1_lo", lo, 32'hFFFF_FFEB);

        do_mul(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0);
        check_eq("t2_hi", hi, 32'h4000_0000);
        check_eq("t2_lo", lo, 32'h0);
        do_mul(2'b00, 32'd3, 32'd5, 1'b0, 32'h0);
        check_eq("t2b_hi", hi, 32'h0);
        check_eq("t2b_lo", lo, 32'd15);

        do_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
`ifdef MULT_UNSIGNED_EN
        check_eq("t3_hi", hi, 32'hFFFF_FFFE);
`else
        check_eq("t3_hi", hi, 32'h0);
`endif
        check_eq("t3_lo", lo, 32'h1);

        do_mul(2'b00, 32'd5, 32'd6, 1'b1, 32'h1234_5678);
        check_eq("t4_hi", hi, 32'h1234_5678);
        check_eq("t4_lo", lo, 32'd30);

        do_abort(32'd9, 32'd9);
        do_mul(2'b00, 32'd2, 32'd2, 1'b0, 32'h0);
        check_eq("t5_lo", lo, 32'd4);
        check_eq("t5_hi", hi, 32'h0);

        do_mov(1'b1, 32'hDEAD_BEEF);
        check_eq("t6_lo", lo, 32'hDEAD_BEEF);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            if (op[1]) do_mov(op[0], pick());
            else do_mul(op, pick(), pick(), $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
